// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package display_pkg;

  // Register map
  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_BLANK_ALL = 0;
  localparam int CTRL_BLINK_EN  = 1;

  // All segments dark (active-low pins)
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan FSM states
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Software-visible register set; MASK is {dp[7:0], enable[7:0]}
  typedef struct packed {
    logic [31:0] value;
    logic [15:0] mask;
    logic [1:0]  ctrl;
  } disp_regs_t;

  localparam disp_regs_t REGS_RST = '{value: 32'h0000_0000, mask: 16'h00FF, ctrl: 2'b00};

endpackage

// File: rtl/seven_segment_display.sv
// Hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seven_segment_display (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph lookup: 0-9, A, b, C, d, E, F
  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Memory-mapped multiplexed seven-segment scanner with blanking gaps and frame-synchronous updates.
// Latency: register write visible next cycle, on pins from next frame start; reads 1 cycle; pins registered.
// Backpressure: none; bus strobes are accepted every cycle and the scan free-runs.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [1:0]            rd_addr,
  output logic [31:0]           rd_data,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]      FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0   = NUM_DIGITS'(1);

  // Bus-side and scan-side register copies
  disp_regs_t bus_q;
  disp_regs_t shd_q;
  disp_regs_t shd_nxt;

  // Scan state
  scan_state_t      state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [FRM_W-1:0] frm_q, frm_nxt;
  logic             blink_on_q, blink_on_nxt;
  logic             frame_start;

  // Next pin values
  logic [3:0]            sel_nibble;
  logic                  sel_en;
  logic                  sel_dp;
  logic [6:0]            hex_seg;
  logic                  blinked_off;
  logic                  lit_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // Bus-side register writes; reserved address and unused bits are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= REGS_RST;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_VALUE: bus_q.value <= wr_data;
        ADDR_MASK:  bus_q.mask  <= wr_data[15:0];
        ADDR_CTRL:  bus_q.ctrl  <= wr_data[1:0];
        default:    ;
      endcase
    end
  end

  // Registered read port; samples pre-write contents so a same-cycle write reads old data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'h0;
    end else if (rd_en) begin
      case (rd_addr)
        ADDR_VALUE: rd_data <= bus_q.value;
        ADDR_MASK:  rd_data <= {16'h0, bus_q.mask};
        ADDR_CTRL:  rd_data <= {30'h0, bus_q.ctrl};
        default:    rd_data <= 32'h0;
      endcase
    end
  end

  // Scan FSM next state: slot timing, digit index wrap, frame and blink phase tracking
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q + CNT_W'(1);
    idx_nxt      = idx_q;
    frm_nxt      = frm_q;
    blink_on_nxt = blink_on_q;
    frame_start  = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_nxt   = SHOW;
          cnt_nxt     = '0;
          frame_start = (idx_q == '0);
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx_q == IDX_LAST) begin
            idx_nxt = '0;
            if (frm_q == FRM_LAST) begin
              frm_nxt      = '0;
              blink_on_nxt = ~blink_on_q;
            end else begin
              frm_nxt = frm_q + FRM_W'(1);
            end
          end else begin
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
    shd_nxt = frame_start ? bus_q : shd_q;
  end

  // Pick the nibble, enable and dp of the digit about to be selected
  always_comb begin
    sel_nibble = 4'h0;
    sel_en     = 1'b0;
    sel_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        sel_nibble = shd_nxt.value[4*i +: 4];
        sel_en     = shd_nxt.mask[i];
        sel_dp     = shd_nxt.mask[8+i];
      end
    end
  end

  // Single shared decoder on the selected nibble
  seven_segment_display u_hex (
    .nibble (sel_nibble),
    .seg_n  (hex_seg)
  );

  // Next pin values: lit only in SHOW with the digit enabled and not blanked or blinked off
  always_comb begin
    blinked_off = shd_nxt.ctrl[CTRL_BLINK_EN] && !blink_on_nxt;
    lit_nxt     = (state_nxt == SHOW) && sel_en && !shd_nxt.ctrl[CTRL_BLANK_ALL] && !blinked_off;
    an_nxt      = '1;
    if (lit_nxt) begin
      an_nxt = ~(ONE_HOT0 << idx_nxt);
    end
    seg_nxt = lit_nxt ? hex_seg : SEG_OFF;
    dp_nxt  = lit_nxt ? ~sel_dp : 1'b1;
  end

  // Scan state, shadow copies and pins update together so pins never lag the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      frm_q      <= '0;
      blink_on_q <= 1'b1;
      shd_q      <= REGS_RST;
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      frm_q      <= frm_nxt;
      blink_on_q <= blink_on_nxt;
      shd_q      <= shd_nxt;
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
    end
  end

endmodule
